// File: rtl/ysyx_23060191_mem_pkg.sv
// rtl/ysyx_23060191_mem_pkg.sv - shared types and constants for the memory responder
package ysyx_23060191_mem_pkg;

  localparam int unsigned MEM_CPU_WIDTH = 32;
  localparam int unsigned MEM_MASK_W    = 4;
  localparam logic [31:0] MEM_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/ysyx_23060191_sram_1rw.sv
// rtl/ysyx_23060191_sram_1rw.sv - single-port word array with byte-enable write
module ysyx_23060191_sram_1rw
  import ysyx_23060191_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = MEM_CPU_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         idx,
  input  logic [DW-1:0]         wdata,
  input  logic [MEM_MASK_W-1:0] wmask,
  output logic [DW-1:0]         rdata
);

  // Contents are deliberately left unreset; simulation may preload them.
  logic [DW-1:0] mem [DEPTH];

  // Byte lanes are written independently so partial stores keep the other bytes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MEM_MASK_W; i++) begin
        if (wmask[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_23060191_mem_responder.sv
// rtl/ysyx_23060191_mem_responder.sv - latency-configurable LSU memory responder
module ysyx_23060191_mem_responder
  import ysyx_23060191_mem_pkg::*;
#(
  parameter int unsigned          CPU_WIDTH   = MEM_CPU_WIDTH,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned          LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [CPU_WIDTH-1:0]  req_addr,
  input  logic [CPU_WIDTH-1:0]  req_wdata,
  input  logic [MEM_MASK_W-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CPU_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  mem_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wen_q, wen_d;
  logic [CPU_WIDTH-1:0]   addr_q, addr_d;
  logic [CPU_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MEM_MASK_W-1:0]  wmask_q, wmask_d;
  logic [CPU_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   commit;
  logic                   c_wen;
  logic [CPU_WIDTH-1:0]   c_addr;
  logic [CPU_WIDTH-1:0]   c_wdata;
  logic [MEM_MASK_W-1:0]  c_wmask;
  logic [CPU_WIDTH-1:0]   offset;
  logic                   fault;
  logic [AW-1:0]          idx;
  logic                   mem_we;
  logic [CPU_WIDTH-1:0]   mem_rdata;

  // Ready is gated by rstn so the LSU sees 0 for the whole time reset is held.
  assign req_ready = rstn & (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY=1 the commit happens on the acceptance edge, so use the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      c_wen   = req_wen;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wmask = req_wmask;
    end else begin
      c_wen   = wen_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_wmask = wmask_q;
    end
  end

  // Addresses below BASE wrap to a huge offset and land in the out-of-range fault.
  assign offset = c_addr - BASE_ADDR;
  assign fault  = (offset[1:0] != 2'b00) | (|offset[CPU_WIDTH-1:AW+2]);
  assign idx    = offset[AW+1:2];
  assign mem_we = commit & rstn & c_wen & ~fault;

  ysyx_23060191_sram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW),
    .DW    (CPU_WIDTH)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (c_wdata),
    .wmask (c_wmask),
    .rdata (mem_rdata)
  );

  // Next-state: accept, count down the latency, commit, then hold the response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d   = fault;
      rdata_d = (fault | c_wen) ? '0 : mem_rdata;
    end
  end

  // State and response registers; reset drops any request still in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_mem_responder.sv
// tb/tb_ysyx_23060191_mem_responder.sv - self-checking bench for the memory responder
module tb_ysyx_23060191_mem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_valid, rsp_err, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;

  logic        l1_req_valid = 1'b0, l1_req_wen = 1'b0, l1_req_ready;
  logic [31:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic [3:0]  l1_req_wmask = '0;
  logic        l1_rsp_valid, l1_rsp_err;
  logic [31:0] l1_rsp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_23060191_mem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  ysyx_23060191_mem_responder #(.CPU_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_wen(l1_req_wen),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata), .req_wmask(l1_req_wmask), .rsp_valid(l1_rsp_valid),
    .rsp_ready(1'b1), .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting, expected a DUT event", name);
  endtask

  // ---------------- behavioural model of the LATENCY=2 responder ----------------
  logic [31:0] mmem [int unsigned];
  int          edge_cnt = 0;
  bit          pending = 0;
  int          acc_edge = 0;
  logic        m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  bit          cmp_en = 0;

  function automatic bit m_fault(input logic [31:0] a);
    longint unsigned la = a;
    longint unsigned lb = BASE;
    return (a % 4 != 0) || (la < lb) || (la >= lb + 4 * DEPTH);
  endfunction

  task automatic model_commit();
    int unsigned idx;
    logic [31:0] w;
    exp_err   = m_fault(m_addr);
    exp_rdata = '0;
    if (!exp_err) begin
      idx = (m_addr - BASE) / 4;
      w = mmem.exists(idx) ? mmem[idx] : 32'h0;
      if (m_wen) begin
        for (int b = 0; b < 4; b++) if (m_mask[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
        mmem[idx] = w;
      end else begin
        exp_rdata = w;
      end
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!rstn) begin
      pending = 0;
    end else if (pending) begin
      if (edge_cnt == acc_edge + LAT) model_commit();
      else if (edge_cnt > acc_edge + LAT && rsp_ready) pending = 0;
    end else if (req_valid) begin
      pending  = 1;
      acc_edge = edge_cnt;
      m_wen    = req_wen;
      m_addr   = req_addr;
      m_wdata  = req_wdata;
      m_mask   = req_wmask;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_req_ready", req_ready, rstn && !pending);
      check("cyc_rsp_valid", rsp_valid, pending && (edge_cnt >= acc_edge + LAT));
      if (rsp_valid) begin
        check("cyc_rsp_rdata", rsp_rdata, exp_rdata);
        check("cyc_rsp_err", rsp_err, exp_err);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wmask = m;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) timeout("accept");
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output int k);
    bit ok = 0;
    k = 0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; ok = 1; break; end
      k++;
    end
    @(posedge clk); #1;
    if (!ok) timeout("response");
  endtask

  task automatic xfer(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      output logic [31:0] rd, output logic er, output int k);
    send(wen, a, d, m);
    wait_rsp(rd, er, k);
  endtask

  logic [31:0] l1_a [6];
  logic [31:0] l1_d [6];
  logic        l1_w [6];
  logic [31:0] l1_exp [6];
  int          l1_acc [6];
  int          l1_hs [6];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          k;
    bit          ok;

    repeat (3) @(posedge clk);
    #1 cmp_en = 1;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);

    xfer(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, rd, er, k);
    check("store_latency", k, LAT);
    check("store_err", er, 0);
    check("store_rdata", rd, 0);
    xfer(0, 32'h8000_0010, 0, 0, rd, er, k);
    check("load_after_store", rd, 32'hDEAD_BEEF);
    check("load_err", er, 0);

    xfer(1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, k);
    xfer(0, 32'h8000_0010, 0, 0, rd, er, k);
    check("byte_mask_load", rd, 32'hDE22_BE44);

    xfer(0, 32'h8000_0012, 0, 0, rd, er, k);
    check("misalign_err", er, 1);
    check("misalign_rdata", rd, 0);

    xfer(1, BASE + 4 * (DEPTH - 1), 32'hCAFE_F00D, 4'b1111, rd, er, k);
    xfer(1, BASE + 4 * DEPTH, 32'h1234_5678, 4'b1111, rd, er, k);
    check("oob_store_err", er, 1);
    xfer(0, BASE + 4 * (DEPTH - 1), 0, 0, rd, er, k);
    check("last_word_unchanged", rd, 32'hCAFE_F00D);

    xfer(0, 32'h7FFF_FFFC, 0, 0, rd, er, k);
    check("below_base_err", er, 1);
    check("below_base_rdata", rd, 0);

    // backpressure window with an ignored request pulse
    rsp_ready = 1'b0;
    send(0, 32'h8000_0010, 0, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) timeout("bp_valid");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wmask = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDE22_BE44);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h8000_0010, 0, 0, rd, er, k);
    check("bp_pulse_ignored", rd, 32'hDE22_BE44);

    // reset while a store waits
    xfer(1, 32'h8000_0020, 32'h0102_0304, 4'b1111, rd, er, k);
    send(1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b1111);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_wait_req_ready", req_ready, 1);
    check("rst_wait_rsp_valid", rsp_valid, 0);
    check("rst_wait_rsp_rdata", rsp_rdata, 0);
    check("rst_wait_rsp_err", rsp_err, 0);
    xfer(0, 32'h8000_0020, 0, 0, rd, er, k);
    check("rst_wait_store_dropped", rd, 32'h0102_0304);

    // LATENCY=1 back-to-back: three stores then three loads
    for (int i = 0; i < 3; i++) begin
      l1_a[i] = BASE + 4 * i;     l1_d[i] = 32'hA5A5_0000 + i; l1_w[i] = 1'b1; l1_exp[i] = 32'h0;
      l1_a[i+3] = BASE + 4 * i;   l1_d[i+3] = 32'h0;           l1_w[i+3] = 1'b0; l1_exp[i+3] = 32'hA5A5_0000 + i;
    end
    @(posedge clk); #1;
    l1_req_valid = 1'b1; l1_req_wen = l1_w[0]; l1_req_addr = l1_a[0]; l1_req_wdata = l1_d[0]; l1_req_wmask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      ok = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (l1_req_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("l1_accept");
      @(posedge clk); #1;
      l1_acc[i] = edge_cnt;
      if (i < 5) begin
        l1_req_wen = l1_w[i+1]; l1_req_addr = l1_a[i+1]; l1_req_wdata = l1_d[i+1];
      end else begin
        l1_req_valid = 1'b0;
      end
      @(negedge clk);
      check("l1_rsp_valid", l1_rsp_valid, 1);
      check("l1_rsp_rdata", l1_rsp_rdata, l1_exp[i]);
      check("l1_rsp_err", l1_rsp_err, 0);
      @(posedge clk); #1;
      l1_hs[i] = edge_cnt;
      if (i > 0) check("l1_spacing", l1_acc[i] - l1_acc[i-1], 2);
    end
    check("l1_three_loads_cycles", l1_hs[5] - l1_acc[3] + 1, 6);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
